// File: rtl/ceespu_uart_tx.sv
// ceespu_uart_tx: memory-mapped 8N1 UART transmitter for the ceespu data bus.
// Stores to TX_ADDR push bytes into a small FIFO; an FSM shifts them out LSB-first.
// A registered status byte {3'b0, parity_en, busy, overflow, empty, full} feeds the read mux.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
// Ports:
//   I_clk          system clock, rising edge
//   I_reset_n      asynchronous active-low reset
//   I_dmemAddress  CPU data-memory address
//   I_dmemData     store data, only [7:0] used
//   I_dmemWe       one-cycle store strobe
//   O_statusData   registered status byte
//   O_txFull       FIFO full, combinational from the count
//   O_tx           registered serial line, idles high
module ceespu_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] TX_ADDR      = 16'hFFF9,
  parameter logic [15:0] STATUS_ADDR  = 16'hFFFA
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic [15:0] I_dmemAddress,
  input  logic [31:0] I_dmemData,
  input  logic        I_dmemWe,
  output logic [7:0]  O_statusData,
  output logic        O_txFull,
  output logic        O_tx
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic       PAR_BIT  = 1'b1;
`else
  localparam logic       PAR_BIT  = 1'b0;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [7:0]       r_status;

  // Serializer state
  logic [2:0]        r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  logic       w_full, w_empty, w_push_req, w_push, w_clr, w_pop, w_baud_done, w_busy;
  logic [7:0] w_head;
  logic       w_unused_data;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push_req  = I_dmemWe && (I_dmemAddress == TX_ADDR);
  assign w_push      = w_push_req && !w_full;
  assign w_clr       = I_dmemWe && (I_dmemAddress == STATUS_ADDR);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_busy      = (r_state != S_IDLE);
  assign w_unused_data = ^I_dmemData[31:8];

  assign O_txFull     = w_full;
  assign O_tx         = r_tx;
  assign O_statusData = r_status;

  // Next-state and line logic; a pop always happens from IDLE or the end of STOP
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^w_head;
`endif
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = r_par;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            // Next bit is shift[1] because the shift lands at this same edge
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            // Back-to-back frame, no idle gap
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = ^w_head;
`endif
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and line registers
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // FIFO data array, no reset needed
  always_ff @(posedge I_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= I_dmemData[7:0];
  end

  // FIFO pointers, count, overflow flag and status byte
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_status <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      // A clear wins over an overflow arriving in the same cycle
      if (w_clr)                     r_ovf <= 1'b0;
      else if (w_push_req && w_full) r_ovf <= 1'b1;
      r_status <= {3'b000, PAR_BIT, w_busy, r_ovf, w_empty, w_full};
    end
  end

endmodule

// File: tb/tb_ceespu_uart_tx.sv
// Testbench for ceespu_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): directed frame table,
// hand-written back-to-back/overflow/reset sequences, then random bus traffic against
// a queue-based reference model of the line.
module tb_ceespu_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [15:0] TX_A = 16'hFFF9;
  localparam logic [15:0] ST_A = 16'hFFFA;
`ifdef UART_TX_PARITY_EN
  localparam int   NB     = 11;
  localparam logic PAR_EN = 1'b1;
`else
  localparam int   NB     = 10;
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int FRAME = NB * CPB;
  localparam logic [7:0] ST_IDLE = {3'b000, PAR_EN, 4'b0010};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_i = 16'h0;
  logic [31:0] data_i = 32'h0;
  logic        we_i = 1'b0;
  logic [7:0]  status_o;
  logic        full_o, tx_o;

  int n_cmp = 0;
  int n_err = 0;

  ceespu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TX_A), .STATUS_ADDR(ST_A)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_dmemAddress(addr_i), .I_dmemData(data_i),
    .I_dmemWe(we_i), .O_statusData(status_o), .O_txFull(full_o), .O_tx(tx_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit b of the serial frame for byte d (start, 8 data LSB first, [parity], stop)
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Hand-written frames (bit 0 = start, bit 9 = stop) and even parity for the table
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t tbl [5];

  function automatic logic tbl_bit(input logic [9:0] f, input logic p, input int b);
    if (NB == 11 && b == 9) return p;
    if (b >= 9) return f[9];
    return f[b];
  endfunction

  task automatic bus_cycle(input logic we, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i = we; addr_i = a; data_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a byte queue plus the position inside the current frame
  bit         mdl_en = 1'b0;
  logic [7:0] mq [$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  logic [7:0] m_est;
  bit         m_full_pre, m_setov;

  always @(posedge clk) begin
    if (mdl_en) begin
      m_est      = {3'b000, PAR_EN, m_act, m_ovf, (mq.size() == 0), (mq.size() == DEPTH)};
      m_full_pre = (mq.size() == DEPTH);
      if (m_act && (m_pos + 1 < FRAME)) m_pos++;
      else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_pos = 0;
        m_act = 1'b1;
      end else m_act = 1'b0;
      m_setov = 1'b0;
      if (we_i && addr_i == TX_A) begin
        if (!m_full_pre) mq.push_back(data_i[7:0]);
        else m_setov = 1'b1;
      end
      if (we_i && addr_i == ST_A) m_ovf = 1'b0;
      else if (m_setov) m_ovf = 1'b1;
      #1;
      chk("rnd_tx", tx_o, m_act ? frame_bit(m_cur, m_pos / CPB) : 1'b1);
      chk("rnd_full", full_o, (mq.size() == DEPTH));
      chk("rnd_status", status_o, m_est);
    end
  end

  initial begin
    int t;
    tbl[0] = '{8'hA5, 10'h34A, 1'b0};
    tbl[1] = '{8'h00, 10'h200, 1'b0};
    tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[3] = '{8'h3C, 10'h278, 1'b0};
    tbl[4] = '{8'h07, 10'h20E, 1'b1};

    // Reset state
    #12;
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_status", status_o, 8'h00);
    chk("rst_full", full_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_status", status_o, ST_IDLE);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_tx", tx_o, 1'b1);
    end

    // Single frames from the table; upper store bits are garbage
    for (int v = 0; v < 5; v++) begin
      bus_cycle(1'b1, TX_A, {$urandom_range(0, 32'hFFFFFF), tbl[v].data});
      chk("no_same_edge_fall", tx_o, 1'b1);
      for (int c = 0; c < FRAME; c++) begin
        step();
        chk("frame_bit", tx_o, tbl_bit(tbl[v].frame, tbl[v].par, c / CPB));
        if (c == FRAME / 2) chk("busy_mid", status_o[3], 1'b1);
      end
      step();
      chk("frame_end_tx", tx_o, 1'b1);
      step();
      chk("frame_end_status", status_o, ST_IDLE);
    end

    // Five back-to-back stores, a sixth overflowing, then a clear
    for (int i = 1; i <= 6; i++) bus_cycle(1'b1, TX_A, 32'(i));
    t = 4;
    chk("full_after5", full_o, 1'b1);
    chk("status_full", status_o, {3'b000, PAR_EN, 4'b1001});
    chk("b2b_tx", tx_o, frame_bit(8'd1, 1));
    step(); t++;
    chk("status_ovf", status_o, {3'b000, PAR_EN, 4'b1101});
    bus_cycle(1'b1, ST_A, 32'hDEAD_BEEF); t++;
    step(); t++;
    chk("status_clr", status_o, {3'b000, PAR_EN, 4'b1001});
    while (t < 5 * FRAME + 3 * CPB) begin
      chk("b2b_tx", tx_o, (t < 5 * FRAME) ? frame_bit(8'(t / FRAME + 1), (t % FRAME) / CPB) : 1'b1);
      if (t == FRAME) chk("full_drop", full_o, 1'b0);
      if (t == 5 * FRAME + 1) chk("b2b_idle_status", status_o, ST_IDLE);
      step(); t++;
    end

    // Reset during DATA bit 3 of 8'hA5 (a 0 bit)
    bus_cycle(1'b1, TX_A, 32'hA5);
    repeat (4 * CPB + 2) step();
    chk("pre_rst_tx", tx_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx_o, 1'b1);
    chk("async_rst_status", status_o, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_status", status_o, ST_IDLE);
    for (int i = 0; i < FRAME; i++) begin
      step();
      chk("post_rst_tx", tx_o, 1'b1);
    end

    // Random traffic against the reference model from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    m_act = 1'b0; m_pos = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 19));
      we_i   = ($urandom_range(0, 3) == 0);
      addr_i = (r < 14) ? TX_A : (r < 17) ? ST_A : 16'($urandom);
      data_i = $urandom;
    end
    @(negedge clk);
    we_i = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    mdl_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
